// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and helpers for the reset sequencer.
//   rst_state_t : sequencer FSM states
//   rst_cause_t : encoding reported on rst_cause
//   cnt_width() : counter width for a count range, never narrower than 1 bit
package reset_seq_pkg;

  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} rst_state_t;

  typedef enum logic [1:0] {CAUSE_POR, CAUSE_BTN, CAUSE_SW, CAUSE_WDOG} rst_cause_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// btn_debounce: synchronizes a raw push-button and filters out bounce.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, clears the stable level to 0
//   btn_i   : raw asynchronous button, active-high
//   level_o : debounced level
//   rise_o  : high in the cycle whose clock edge raises level_o (combinational)
module btn_debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // The counter only runs while the synced input differs from the stable
  // level; any return to the stable level clears it, so a bounce restarts it.
  assign flip = (sync2_q != level_q) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (flip) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  // Announced in the same cycle the level flips, so the sequencer reacts on
  // the edge that raises the debounced level.
  assign rise_o  = flip & sync2_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: generates staged domain resets from board reset, push-button,
// software request and (optionally) a watchdog.
//   clk          : system clock
//   CPU_RESETN   : board reset, asynchronous active-low
//   btn_rst_req  : raw push-button, asynchronous active-high
//   sw_rst_req   : software reset request, one-cycle pulse
//   wdog_kick    : watchdog service pulse
//   rst_out      : active-high domain resets, bit 0 released first
//   rst_done     : high once every stage is released
//   rst_cause    : cause of last reset (0 POR, 1 button, 2 software, 3 watchdog)
// Build option: define RESET_SEQ_WDOG_EN to include the watchdog.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_GAP       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned WDOG_CYCLES     = 2**24
) (
  input  logic                  clk,
  input  logic                  CPU_RESETN,
  input  logic                  btn_rst_req,
  input  logic                  sw_rst_req,
  input  logic                  wdog_kick,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  rst_done,
  output logic [1:0]            rst_cause
);

  localparam int unsigned       HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam int unsigned       GAP_W     = cnt_width(STAGE_GAP);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  logic                  rstn_meta_q, rstn_sync_q;
  logic                  btn_level, btn_rise;
  logic                  wdog_exp;
  logic                  req, src_active;
  rst_cause_t            req_cause;
  rst_state_t            state_q, state_d;
  rst_cause_t            cause_q, cause_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d, rst_shift;
  logic                  rst_done_q, rst_done_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [GAP_W-1:0]      gap_q, gap_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i  (clk),
    .rst_ni (CPU_RESETN),
    .btn_i  (btn_rst_req),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  // Reset assertion is asynchronous; release is seen by the hold counter only
  // after two flops, so the count starts cleanly after the board reset rises.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rstn_meta_q <= 1'b0;
      rstn_sync_q <= 1'b0;
    end else begin
      rstn_meta_q <= 1'b1;
      rstn_sync_q <= rstn_meta_q;
    end
  end

`ifdef RESET_SEQ_WDOG_EN
  localparam int unsigned      WD_W    = cnt_width(WDOG_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // A kick in the expiry cycle wins; outside RUN the counter is held clear.
  assign wdog_exp = (state_q == RUN) && !wdog_kick && (wd_q == WD_LAST);

  always_comb begin
    wd_d = '0;
    if ((state_q == RUN) && !wdog_kick && (wd_q != WD_LAST)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
  logic unused_wdog_kick;

  assign unused_wdog_kick = wdog_kick;
  assign wdog_exp         = 1'b0;
`endif

  assign req        = btn_rise | sw_rst_req | wdog_exp;
  assign req_cause  = btn_rise   ? CAUSE_BTN :
                      sw_rst_req ? CAUSE_SW  : CAUSE_WDOG;
  assign src_active = !rstn_sync_q || btn_level;
  // Releasing a stage clears the lowest still-asserted bit; outputs only ever
  // move toward deasserted, in stage order.
  assign rst_shift  = rst_out_q << 1;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    rst_out_d  = rst_out_q;
    rst_done_d = rst_done_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    if (req) begin
      state_d    = ASSERT;
      cause_d    = req_cause;
      rst_out_d  = '1;
      rst_done_d = 1'b0;
      hold_d     = '0;
      gap_d      = '0;
    end else begin
      case (state_q)
        ASSERT: begin
          if (src_active) begin
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d    = '0;
            gap_d     = '0;
            rst_out_d = rst_shift;
            if (rst_shift == '0) begin
              state_d    = RUN;
              rst_done_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d     = '0;
            rst_out_d = rst_shift;
            if (rst_shift == '0) begin
              state_d    = RUN;
              rst_done_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        RUN: begin
        end
        default: begin
          state_d    = ASSERT;
          rst_out_d  = '1;
          rst_done_d = 1'b0;
          hold_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= ASSERT;
      cause_q    <= CAUSE_POR;
      rst_out_q  <= '1;
      rst_done_q <= 1'b0;
      hold_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      rst_out_q  <= rst_out_d;
      rst_done_q <= rst_done_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_done  = rst_done_q;
  assign rst_cause = cause_q;

endmodule
